vpi_check_sched: RTL and testbench

- Sequencer that drives a bank of NUM_ARR public array checkers (sig/rfr/check slots of increasing length) from a single shared write bus.
- For each slot in turn: load a pseudo-random pattern into sig and rfr, pulse check, sample the slot's mismatch flag, tally pass/fail.
- Sits beside the test top, under the same clock as count/half_count.
- Lets the bench self-check the array slots without VPI, and gives VPI a known state to read back.

---
 rtl/vpi_check_pkg.sv | 34 +++
 rtl/vpi_check_lfsr.sv | 39 +++
 rtl/vpi_check_sched.sv | 177 +++++++++++++++++
 tb/tb_vpi_check_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vpi_check_pkg.sv
// vpi_check_pkg: shared types, LFSR taps and mask helper for the array-checker
// sequencer (vpi_check_sched) and its LFSR (vpi_check_lfsr).
package vpi_check_pkg;

  // Sequencer states; one slot walks LOAD_SIG..SAMPLE (5 cycles)
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_SIG = 3'd1,
    S_LOAD_RFR = 3'd2,
    S_CHECK    = 3'd3,
    S_WAIT     = 3'd4,
    S_SAMPLE   = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  // 32-bit Fibonacci LFSR feedback taps
  localparam int unsigned LFSR_W = 32;
  localparam int unsigned TAP_A  = 31;
  localparam int unsigned TAP_B  = 21;
  localparam int unsigned TAP_C  = 1;
  localparam int unsigned TAP_D  = 0;

  // Upper bound on write-bus width supported by mask_n
  localparam int unsigned MASK_MAX_W = 1024;

  // Low n bits set, clamped to w bits; callers truncate to their bus width
  function automatic logic [MASK_MAX_W-1:0] mask_n(input int unsigned n,
                                                   input int unsigned w);
    int unsigned nn;
    nn = (n < w) ? n : w;
    return ~({MASK_MAX_W{1'b1}} << nn);
  endfunction

endpackage

// File: rtl/vpi_check_lfsr.sv
// vpi_check_lfsr: 32-bit Fibonacci LFSR with synchronous load-to-seed and
// advance controls.
// Ports: clk, rst (sync, active-high); load (reseed), advance (one step);
//        value (registered state), next_c (combinational next state).
module vpi_check_lfsr
  import vpi_check_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  output logic [LFSR_W-1:0] value,
  output logic [LFSR_W-1:0] next_c
);

  logic fb;

  // Next-state select: load wins over advance
  always_comb begin
    fb     = value[TAP_A] ^ value[TAP_B] ^ value[TAP_C] ^ value[TAP_D];
    next_c = value;
    if (load) begin
      next_c = SEED;
    end else if (advance) begin
      next_c = {value[LFSR_W-2:0], fb};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= SEED;
    end else begin
      value <= next_c;
    end
  end

endmodule

// File: rtl/vpi_check_sched.sv
// vpi_check_sched: walks NUM_ARR checker slots (slot i is i+1 bits wide),
// writing a pseudo-random pattern to sig then rfr, strobing check, sampling
// the slot's mismatch flag and tallying pass/fail.
// Ports: clk, rst (sync, active-high); start, inject, inject_idx (sweep
//        control); busy, done (status); idx, wr_en, wr_sel, wr_data,
//        check_pulse (slot bus); mismatch_in (slot result); pass_cnt,
//        fail_cnt, first_fail, any_fail (sweep results).
// Requires NUM_ARR >= 2 and WIDTH a multiple of 32 with WIDTH >= NUM_ARR.
module vpi_check_sched
  import vpi_check_pkg::*;
#(
  parameter int unsigned       NUM_ARR = 128,
  parameter int unsigned       WIDTH   = 128,
  parameter logic [LFSR_W-1:0] SEED    = 32'h0000_0001,
  parameter int unsigned       IDX_W   = $clog2(NUM_ARR),
  parameter int unsigned       CNT_W   = $clog2(NUM_ARR + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             inject,
  input  logic [IDX_W-1:0] inject_idx,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] idx,
  output logic             wr_en,
  output logic             wr_sel,
  output logic [WIDTH-1:0] wr_data,
  output logic             check_pulse,
  input  logic             mismatch_in,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [IDX_W-1:0] first_fail,
  output logic             any_fail
);

  localparam int unsigned REP = WIDTH / LFSR_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ARR - 1);

  state_t state_q, state_d;

  logic             accept;
  logic             lfsr_adv;
  logic [IDX_W-1:0] idx_d;
  logic             inj_en_q, inj_en_d;
  logic [IDX_W-1:0] inj_idx_q, inj_idx_d;
  logic [CNT_W-1:0] pass_d, fail_d;
  logic [IDX_W-1:0] first_fail_d;
  logic             any_fail_d;

  logic [LFSR_W-1:0] lfsr_value, lfsr_next, lfsr_src;
  logic [WIDTH-1:0]  mask, pat;
  logic              inj_hit;
  logic              wr_en_d, wr_sel_d, check_d, done_d, busy_d;
  logic [WIDTH-1:0]  wr_data_d;

  vpi_check_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .advance (lfsr_adv),
    .value   (lfsr_value),
    .next_c  (lfsr_next)
  );

  // Next state, slot index, sweep latches and tallies
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    lfsr_adv     = 1'b0;
    idx_d        = idx;
    inj_en_d     = inj_en_q;
    inj_idx_d    = inj_idx_q;
    pass_d       = pass_cnt;
    fail_d       = fail_cnt;
    first_fail_d = first_fail;
    any_fail_d   = any_fail;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept       = 1'b1;
          state_d      = S_LOAD_SIG;
          idx_d        = '0;
          inj_en_d     = inject;
          inj_idx_d    = inject_idx;
          pass_d       = '0;
          fail_d       = '0;
          first_fail_d = '0;
          any_fail_d   = 1'b0;
        end
      end
      S_LOAD_SIG: state_d = S_LOAD_RFR;
      S_LOAD_RFR: state_d = S_CHECK;
      S_CHECK:    state_d = S_WAIT;
      S_WAIT:     state_d = S_SAMPLE;
      S_SAMPLE: begin
        lfsr_adv = 1'b1;
        if (mismatch_in) begin
          fail_d = fail_cnt + CNT_W'(1);
          if (!any_fail) begin
            first_fail_d = idx;
          end
          any_fail_d = 1'b1;
        end else begin
          pass_d = pass_cnt + CNT_W'(1);
        end
        if (idx == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx + IDX_W'(1);
          state_d = S_LOAD_SIG;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered slot-bus outputs, decoded from state_d.
  // Entering LOAD_SIG the LFSR is reseeded or stepped on the same edge, so
  // the pattern comes from its next value; LOAD_RFR follows LOAD_SIG with the
  // LFSR unchanged, so the current value is the same pattern source.
  always_comb begin
    lfsr_src  = (state_q == S_LOAD_SIG) ? lfsr_value : lfsr_next;
    mask      = WIDTH'(mask_n(32'(idx_d) + 32'd1, WIDTH));
    pat       = {REP{lfsr_src}} & mask;
    inj_hit   = inj_en_q && (inj_idx_q == idx_d);
    wr_en_d   = (state_d == S_LOAD_SIG) || (state_d == S_LOAD_RFR);
    wr_sel_d  = (state_d == S_LOAD_RFR);
    check_d   = (state_d == S_CHECK);
    done_d    = (state_d == S_DONE);
    busy_d    = (state_d != S_IDLE);
    wr_data_d = '0;
    if (state_d == S_LOAD_SIG) begin
      wr_data_d = pat;
    end else if (state_d == S_LOAD_RFR) begin
      wr_data_d = pat ^ {{(WIDTH-1){1'b0}}, inj_hit};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx         <= '0;
      inj_en_q    <= 1'b0;
      inj_idx_q   <= '0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      first_fail  <= '0;
      any_fail    <= 1'b0;
      wr_en       <= 1'b0;
      wr_sel      <= 1'b0;
      wr_data     <= '0;
      check_pulse <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx         <= idx_d;
      inj_en_q    <= inj_en_d;
      inj_idx_q   <= inj_idx_d;
      pass_cnt    <= pass_d;
      fail_cnt    <= fail_d;
      first_fail  <= first_fail_d;
      any_fail    <= any_fail_d;
      wr_en       <= wr_en_d;
      wr_sel      <= wr_sel_d;
      wr_data     <= wr_data_d;
      check_pulse <= check_d;
      done        <= done_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_vpi_check_sched.sv
// tb_vpi_check_sched: directed bench for vpi_check_sched. A 4-slot/32-bit
// instance runs against a slot model that echoes sig != rfr; a
// 128-slot/128-bit instance runs with forced mismatches in slots 5 and 100.
// Cycle c is the cycle c clock edges after the one that accepts start.
module tb_vpi_check_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Small instance (NUM_ARR=4, WIDTH=32)
  logic        s_start, s_inject, s_busy, s_done, s_wr_en, s_wr_sel, s_check;
  logic        s_mismatch, s_any_fail;
  logic [1:0]  s_inject_idx, s_idx, s_first_fail;
  logic [31:0] s_wr_data;
  logic [2:0]  s_pass, s_fail;

  // Large instance (NUM_ARR=128, WIDTH=128)
  logic         b_start, b_inject, b_busy, b_done, b_wr_en, b_wr_sel, b_check;
  logic         b_mismatch, b_any_fail;
  logic [6:0]   b_inject_idx, b_idx, b_first_fail;
  logic [127:0] b_wr_data;
  logic [7:0]   b_pass, b_fail;

  vpi_check_sched #(.NUM_ARR(4), .WIDTH(32), .SEED(32'h1)) u_dut_small (
    .clk(clk), .rst(rst), .start(s_start), .inject(s_inject),
    .inject_idx(s_inject_idx), .busy(s_busy), .done(s_done), .idx(s_idx),
    .wr_en(s_wr_en), .wr_sel(s_wr_sel), .wr_data(s_wr_data),
    .check_pulse(s_check), .mismatch_in(s_mismatch), .pass_cnt(s_pass),
    .fail_cnt(s_fail), .first_fail(s_first_fail), .any_fail(s_any_fail)
  );

  vpi_check_sched #(.NUM_ARR(128), .WIDTH(128), .SEED(32'h1)) u_dut_big (
    .clk(clk), .rst(rst), .start(b_start), .inject(b_inject),
    .inject_idx(b_inject_idx), .busy(b_busy), .done(b_done), .idx(b_idx),
    .wr_en(b_wr_en), .wr_sel(b_wr_sel), .wr_data(b_wr_data),
    .check_pulse(b_check), .mismatch_in(b_mismatch), .pass_cnt(b_pass),
    .fail_cnt(b_fail), .first_fail(b_first_fail), .any_fail(b_any_fail)
  );

  // Slot model for the small instance: latch sig != rfr on check
  logic [31:0] sig_m [4];
  logic [31:0] rfr_m [4];
  logic        mm_m  [4];
  always @(posedge clk) begin
    if (s_wr_en) begin
      if (s_wr_sel) rfr_m[s_idx] <= s_wr_data;
      else          sig_m[s_idx] <= s_wr_data;
    end
    if (s_check) mm_m[s_idx] <= (sig_m[s_idx] != rfr_m[s_idx]);
  end
  assign s_mismatch = mm_m[s_idx];

  assign b_mismatch = (b_idx == 7'd5) || (b_idx == 7'd100);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  // Per-cycle record of the small instance
  logic        rec_wr_en   [64];
  logic        rec_wr_sel  [64];
  logic [31:0] rec_wr_data [64];
  logic        rec_check   [64];
  logic        rec_done    [64];
  logic        rec_busy    [64];
  int          done_count;

  logic [31:0] exp_pat [4];

  // mode 0: single start pulse; 1: extra starts in cycles 3 and 21;
  // 2: start held through cycle 49; 3: rst in cycle 9
  task automatic run_small(input logic inj, input logic [1:0] iidx,
                           input int mode, input int ncyc);
    int strobe_clash;
    strobe_clash = 0;
    done_count   = 0;
    s_inject     = inj;
    s_inject_idx = iidx;
    s_start      = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      rec_wr_en[c]   = s_wr_en;
      rec_wr_sel[c]  = s_wr_sel;
      rec_wr_data[c] = s_wr_data;
      rec_check[c]   = s_check;
      rec_done[c]    = s_done;
      rec_busy[c]    = s_busy;
      if (s_done) done_count++;
      if (s_wr_en && s_check) strobe_clash++;
      if (mode == 3 && c == 10) begin
        check("rst_idx",   s_idx, 0);
        check("rst_busy",  s_busy, 0);
        check("rst_wr_en", s_wr_en, 0);
        check("rst_data",  s_wr_data, 0);
        check("rst_chk",   s_check, 0);
        check("rst_pass",  s_pass, 0);
        check("rst_fail",  s_fail, 0);
        check("rst_any",   s_any_fail, 0);
      end
      case (mode)
        1:       s_start = (c + 1 == 3) || (c + 1 == 21);
        2:       s_start = (c + 1 < 50);
        default: s_start = 1'b0;
      endcase
      rst = (mode == 3) && (c + 1 == 9);
    end
    s_start = 1'b0;
    rst     = 1'b0;
    check("strobe_excl", strobe_clash, 0);
    for (int k = 0; k < 200 && s_busy; k++) tick();
    check("drain_idle", s_busy, 0);
  endtask

  task automatic check_patterns(input string tag, input int base);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_sig_en%0d", tag, k), rec_wr_en[base + 5*k], 1);
      check($sformatf("%s_sig_sel%0d", tag, k), rec_wr_sel[base + 5*k], 0);
      check($sformatf("%s_sig%0d", tag, k), rec_wr_data[base + 5*k], exp_pat[k]);
      check($sformatf("%s_chk%0d", tag, k), rec_check[base + 5*k + 2], 1);
    end
  endtask

  initial begin
    logic [31:0]  l;
    logic [127:0] b_slot0, b_slot127;
    int           b_done_cyc;

    exp_pat[0] = 32'h1;
    exp_pat[1] = 32'h3;
    exp_pat[2] = 32'h6;
    exp_pat[3] = 32'hD;

    rst = 1'b1; s_start = 1'b0; s_inject = 1'b0; s_inject_idx = '0;
    b_start = 1'b0; b_inject = 1'b0; b_inject_idx = '0;
    tick(); tick();
    check("reset_busy",   s_busy, 0);
    check("reset_done",   s_done, 0);
    check("reset_idx",    s_idx, 0);
    check("reset_wr_en",  s_wr_en, 0);
    check("reset_data",   s_wr_data, 0);
    check("reset_cnts",   {s_pass, s_fail}, 0);
    check("reset_ff",     {s_first_fail, s_any_fail}, 0);
    check("reset_b_all",  {b_busy, b_done, b_wr_en, b_check, b_pass, b_fail,
                           b_first_fail, b_any_fail}, 0);
    rst = 1'b0;
    tick();

    // Clean sweep
    run_small(1'b0, 2'd0, 0, 25);
    check_patterns("clean", 1);
    for (int k = 0; k < 4; k++)
      check($sformatf("clean_rfr%0d", k), rec_wr_data[5*k + 2], exp_pat[k]);
    check("clean_done20", rec_done[20], 0);
    check("clean_done21", rec_done[21], 1);
    check("clean_ndone",  done_count, 1);
    check("clean_pass",   s_pass, 4);
    check("clean_fail",   s_fail, 0);
    check("clean_any",    s_any_fail, 0);
    check("clean_ff",     s_first_fail, 0);

    // Corrupt slot 2's rfr write
    run_small(1'b1, 2'd2, 0, 25);
    check("inj_sig2",  rec_wr_data[11], 32'h6);
    check("inj_rfr2",  rec_wr_data[12], 32'h7);
    check("inj_rfr1",  rec_wr_data[7],  32'h3);
    check("inj_pass",  s_pass, 3);
    check("inj_fail",  s_fail, 1);
    check("inj_ff",    s_first_fail, 2);
    check("inj_any",   s_any_fail, 1);

    // Starts while busy / in DONE are ignored
    run_small(1'b0, 2'd0, 1, 25);
    check("ign_ndone",  done_count, 1);
    check("ign_done21", rec_done[21], 1);
    for (int c = 1; c <= 21; c++) check($sformatf("ign_busy%0d", c), rec_busy[c], 1);
    check("ign_busy22", rec_busy[22], 0);
    check("ign_wr23",   rec_wr_en[23], 0);

    // Reset mid-sweep, then a fresh sweep reproduces the clean results
    run_small(1'b0, 2'd0, 3, 25);
    check("abort_ndone", done_count, 0);
    check("abort_idle",  rec_busy[12], 0);
    run_small(1'b0, 2'd0, 0, 25);
    check_patterns("rerun", 1);
    check("rerun_pass", s_pass, 4);
    check("rerun_fail", s_fail, 0);

    // Start held: IDLE after DONE accepts it, LFSR reseeded
    run_small(1'b0, 2'd0, 2, 50);
    check("held_done21", rec_done[21], 1);
    check("held_busy22", rec_busy[22], 0);
    check("held_wr22",   rec_wr_en[22], 0);
    check("held_wr23",   rec_wr_en[23], 1);
    check_patterns("held2", 23);
    check("held_done43", rec_done[43], 1);

    // Large instance: forced failures in slots 5 and 100
    b_done_cyc = 0;
    b_slot0    = '0;
    b_slot127  = '0;
    b_start    = 1'b1;
    for (int c = 1; c <= 700 && b_done_cyc == 0; c++) begin
      tick();
      b_start = 1'b0;
      if (b_wr_en && !b_wr_sel && b_idx == 7'd0)   b_slot0   = b_wr_data;
      if (b_wr_en && !b_wr_sel && b_idx == 7'd127) b_slot127 = b_wr_data;
      if (b_done) b_done_cyc = c;
    end
    l = 32'h1;
    for (int k = 0; k < 127; k++) l = lfsr_step(l);
    check("big_done_cyc", b_done_cyc, 641);
    check("big_pass",     b_pass, 126);
    check("big_fail",     b_fail, 2);
    check("big_ff",       b_first_fail, 5);
    check("big_any",      b_any_fail, 1);
    check("big_slot0",    b_slot0, 128'h1);
    check("big_slot127",  b_slot127, {4{l}});
    tick(); tick();
    check("big_hold_pass", b_pass, 126);
    check("big_idle",      b_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
